// File: rtl/mc6820_pia_pkg.sv
// mc6820_pia_pkg: register-select addresses and control-register bit positions
package mc6820_pia_pkg;
    localparam logic [1:0] RS_ORA = 2'd0;
    localparam logic [1:0] RS_CRA = 2'd1;
    localparam logic [1:0] RS_ORB = 2'd2;
    localparam logic [1:0] RS_CRB = 2'd3;
    localparam int CR_IRQ1    = 7;
    localparam int CR_IRQ2    = 6;
    localparam int CR_C2_OUT  = 5;
    localparam int CR_C2_EDGE = 4;
    localparam int CR_C2_EN   = 3;
    localparam int CR_OR_SEL  = 2;
    localparam int CR_C1_EDGE = 1;
    localparam int CR_C1_EN   = 0;
endpackage

// File: rtl/mc6820_pia_port.sv
// pia_port: one PIA side with DDR/OR/CR, C1/C2 edge flags, C2 output modes and irq
module pia_port
    import mc6820_pia_pkg::*;
#(
    parameter bit READ_STROBE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  logic       rw,
    input  logic       ctrl,
    input  logic [7:0] di,
    input  logic [7:0] pi,
    input  logic       c1,
    input  logic       c2i,
    output logic [7:0] po,
    output logic       c2o,
    output logic       irq,
    output logic [7:0] rd
);
    logic [7:0] ddr, or_r, cr, pin;
    logic c1_q, c2_q, hs;
    logic wr_en, cr_we, or_rd, or_wr, strobe, c1_edge, c2_edge, c2_out_n;

    assign wr_en    = sel & ~rw;
    assign cr_we    = wr_en & ctrl;
    assign or_rd    = sel & rw & ~ctrl & cr[CR_OR_SEL];
    assign or_wr    = wr_en & ~ctrl & cr[CR_OR_SEL];
    assign strobe   = READ_STROBE ? or_rd : or_wr;
    assign c1_edge  = cr[CR_C1_EDGE] ? (c1 & ~c1_q) : (~c1 & c1_q);
    assign c2_edge  = cr[CR_C2_EDGE] ? (c2i & ~c2_q) : (~c2i & c2_q);
    assign c2_out_n = cr_we ? di[CR_C2_OUT] : cr[CR_C2_OUT];
    assign pin      = (or_r & ddr) | (pi & ~ddr);
    assign po       = or_r & ddr;
    assign rd       = ctrl ? cr : (cr[CR_OR_SEL] ? pin : ddr);
    assign c2o      = ~cr[CR_C2_OUT] ? 1'b1 : (cr[CR_C2_EDGE] ? cr[CR_C2_EN] : hs);
    assign irq      = ~((cr[CR_IRQ1] & cr[CR_C1_EN]) |
                        (cr[CR_IRQ2] & cr[CR_C2_EN] & ~cr[CR_C2_OUT]));

    // CPU-visible registers; flag sets take priority over the clear caused by an OR read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ddr  <= 8'h00;
            or_r <= 8'h00;
            cr   <= 8'h00;
        end else begin
            if (wr_en & ~ctrl & ~cr[CR_OR_SEL]) ddr <= di;
            if (or_wr) or_r <= di;
            if (cr_we) cr[5:0] <= di[5:0];
            cr[CR_IRQ1] <= c1_edge | (cr[CR_IRQ1] & ~or_rd);
            cr[CR_IRQ2] <= ~c2_out_n & (c2_edge | (cr[CR_IRQ2] & ~or_rd));
        end
    end

    // edge history and the handshake/pulse level driven on C2 in strobe modes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c1_q <= 1'b1;
            c2_q <= 1'b1;
            hs   <= 1'b1;
        end else begin
            c1_q <= c1;
            c2_q <= c2i;
            hs   <= ~(cr[CR_C2_OUT] & ~cr[CR_C2_EDGE]) ? 1'b1 :
                    cr[CR_C2_EN] ? ~strobe :
                    strobe ? 1'b0 : (c1_edge ? 1'b1 : hs);
        end
    end
endmodule

// File: rtl/mc6820_pia.sv
// mc6820_pia: two-port peripheral interface adapter, A side read-strobed, B side write-strobed
module mc6820_pia
    import mc6820_pia_pkg::*;
(
    input  logic       enable,
    input  logic       reset,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic [7:0] PAI,
    input  logic [7:0] PBI,
    output logic [7:0] PAO,
    output logic [7:0] PBO,
    input  logic       CA1,
    input  logic       CB1,
    input  logic       CA2I,
    input  logic       CB2I,
    output logic       CA2O,
    output logic       CB2O,
    input  logic [2:0] CS,
    input  logic [1:0] RS,
    input  logic       rw,
    output logic       irqA,
    output logic       irqB
);
    logic sel, a_hit, ctrl;
    logic [7:0] a_rd, b_rd;

    assign sel   = CS[0] & CS[1] & ~CS[2];
    assign a_hit = (RS == RS_ORA) | (RS == RS_CRA);
    assign ctrl  = (RS == RS_CRA) | (RS == RS_CRB);
    assign DO    = (sel & rw & ~reset) ? (a_hit ? a_rd : b_rd) : 8'h00;

    pia_port #(.READ_STROBE(1'b1)) u_a (
        .clk(enable), .rst(reset), .sel(sel & a_hit), .rw(rw), .ctrl(ctrl),
        .di(DI), .pi(PAI), .c1(CA1), .c2i(CA2I),
        .po(PAO), .c2o(CA2O), .irq(irqA), .rd(a_rd)
    );

    pia_port #(.READ_STROBE(1'b0)) u_b (
        .clk(enable), .rst(reset), .sel(sel & ~a_hit), .rw(rw), .ctrl(ctrl),
        .di(DI), .pi(PBI), .c1(CB1), .c2i(CB2I),
        .po(PBO), .c2o(CB2O), .irq(irqB), .rd(b_rd)
    );
endmodule

// File: tb/tb_mc6820_pia.sv
// tb_mc6820_pia: directed register, flag, C2-mode and chip-select checks for mc6820_pia
module tb_mc6820_pia;
    logic       enable = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] DI = 8'h00, PAI = 8'hFF, PBI = 8'h00;
    logic [7:0] DO, PAO, PBO;
    logic       CA1 = 1'b1, CB1 = 1'b1, CA2I = 1'b1, CB2I = 1'b1;
    logic       CA2O, CB2O, irqA, irqB;
    logic [2:0] CS = 3'b000;
    logic [1:0] RS = 2'd0;
    logic       rw = 1'b1;
    int         n_checks = 0;
    int         n_fail = 0;

    mc6820_pia dut (
        .enable(enable), .reset(reset), .DI(DI), .DO(DO), .PAI(PAI), .PBI(PBI),
        .PAO(PAO), .PBO(PBO), .CA1(CA1), .CB1(CB1), .CA2I(CA2I), .CB2I(CB2I),
        .CA2O(CA2O), .CB2O(CB2O), .CS(CS), .RS(RS), .rw(rw), .irqA(irqA), .irqB(irqB)
    );

    always #5 enable = ~enable;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        CS = 3'b000;
        rw = 1'b1;
    endtask

    task automatic wr(input logic [1:0] rs, input logic [7:0] d, input logic [2:0] cs = 3'b011);
        @(negedge enable);
        CS = cs; rw = 1'b0; RS = rs; DI = d;
        @(negedge enable);
        idle();
    endtask

    task automatic rd(input string tag, input logic [1:0] rs, input logic [7:0] exp,
                      input logic [2:0] cs = 3'b011);
        @(negedge enable);
        CS = cs; rw = 1'b1; RS = rs;
        #1 chk(tag, DO, exp);
        @(negedge enable);
        idle();
    endtask

    task automatic cyc();
        @(negedge enable);
    endtask

    initial begin
        CS = 3'b011; rw = 1'b1; RS = 2'd0;
        repeat (2) cyc();
        chk("rst_do", DO, 8'h00);
        chk("rst_pao", PAO, 8'h00);
        chk("rst_c2o", {6'd0, CA2O, CB2O}, 8'h03);
        chk("rst_irq", {6'd0, irqA, irqB}, 8'h03);
        idle();
        reset = 1'b0;
        rd("cra_after_rst", 2'd1, 8'h00);
        chk("irq_after_rst", {6'd0, irqA, irqB}, 8'h03);
        wr(2'd1, 8'h01);
        CA1 = 1'b0;
        rd("cra_ca1_fall", 2'd1, 8'h81);
        chk("irqa_ca1", {7'd0, irqA}, 8'h00);
        CA1 = 1'b1;
        rd("cra_ca1_rise", 2'd1, 8'h81);
        wr(2'd1, 8'h05);
        rd("cra_ro_flags", 2'd1, 8'h85);
        rd("ora_pins", 2'd0, 8'hFF);
        rd("cra_cleared", 2'd1, 8'h05);
        chk("irqa_cleared", {7'd0, irqA}, 8'h01);
        PAI = 8'hF0;
        wr(2'd1, 8'h00);
        wr(2'd0, 8'h0F);
        wr(2'd1, 8'h04);
        wr(2'd0, 8'hA5);
        chk("pao_mask", PAO, 8'h05);
        rd("ora_mixed", 2'd0, 8'hF5);
        wr(2'd1, 8'h2C);
        chk("ca2_pulse_idle", {7'd0, CA2O}, 8'h01);
        rd("ora_pulse_rd", 2'd0, 8'hF5);
        chk("ca2_pulse_low", {7'd0, CA2O}, 8'h00);
        cyc();
        chk("ca2_pulse_end", {7'd0, CA2O}, 8'h01);
        wr(2'd3, 8'h24);
        chk("cb2_hs_idle", {7'd0, CB2O}, 8'h01);
        wr(2'd2, 8'h3C);
        chk("cb2_hs_low", {7'd0, CB2O}, 8'h00);
        repeat (2) cyc();
        chk("cb2_hs_hold", {7'd0, CB2O}, 8'h00);
        chk("pbo_no_ddr", PBO, 8'h00);
        CB1 = 1'b0;
        cyc();
        chk("cb2_hs_release", {7'd0, CB2O}, 8'h01);
        rd("crb_cb1_flag", 2'd3, 8'hA4);
        chk("irqb_masked", {7'd0, irqB}, 8'h01);
        PBI = 8'h5A;
        rd("orb_pins", 2'd2, 8'h5A);
        rd("crb_cleared", 2'd3, 8'h24);
        wr(2'd3, 8'h09);
        chk("irqb_idle", {7'd0, irqB}, 8'h01);
        chk("cb2_input_mode", {7'd0, CB2O}, 8'h01);
        CB2I = 1'b0;
        cyc();
        chk("irqb_cb2", {7'd0, irqB}, 8'h00);
        rd("crb_cb2_flag", 2'd3, 8'h49);
        rd("cs_bad_rd", 2'd3, 8'h00, 3'b111);
        wr(2'd3, 8'h00, 3'b111);
        wr(2'd0, 8'hFF, 3'b111);
        rd("cs_bad_wr_crb", 2'd3, 8'h49);
        chk("cs_bad_wr_pao", PAO, 8'h05);
        wr(2'd3, 8'h0D);
        CB2I = 1'b1;
        cyc();
        @(negedge enable);
        CB2I = 1'b0; CS = 3'b011; rw = 1'b1; RS = 2'd2;
        #1 chk("orb_set_wins_rd", DO, 8'h5A);
        @(negedge enable);
        idle();
        rd("crb_set_wins", 2'd3, 8'h4D);
        @(negedge enable);
        CS = 3'b011; rw = 1'b0; RS = 2'd1; DI = 8'hFF;
        #2 reset = 1'b1;
        @(negedge enable);
        idle();
        reset = 1'b0;
        rd("cra_abort", 2'd1, 8'h00);
        chk("pao_abort", PAO, 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mc6820_pia.md
MC6820_PIA -- requirements
Module: mc6820_pia

Interface
REQ-001 SHALL have no parameters; all widths fixed.
REQ-002 enable  in  1  sole clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 DI  in  8  CPU write data.
REQ-005 DO  out  8  CPU read data.
REQ-006 PAI, PBI  in  8 each  port A / port B pin inputs.
REQ-007 PAO, PBO  out  8 each  port A / port B output drive values.
REQ-008 CA1, CB1  in  1 each  interrupt inputs.
REQ-009 CA2I, CB2I  in  1 each  CA2 / CB2 pin inputs.
REQ-010 CA2O, CB2O  out  1 each  CA2 / CB2 pin outputs.
REQ-011 CS  in  3  chip selects; selected = CS[0] & CS[1] & ~CS[2].
REQ-012 RS  in  2  register select.
REQ-013 rw  in  1  1 = read, 0 = write.
REQ-014 irqA, irqB  out  1 each  interrupt requests, active-low.

Function
REQ-015 Registers per side x in {A,B}: DDRx[7:0], ORx[7:0], CRx[7:0].
REQ-016 Address map: RS=00 gives ORA when CRA[2]=1, else DDRA; RS=01 gives CRA; RS=10 gives ORB when CRB[2]=1, else DDRB; RS=11 gives CRB.
REQ-017 Write: when selected and rw=0, the addressed register loads DI at the clock edge; CRx[7:6] are read-only flags and are unaffected by writes.
REQ-018 Read: when selected and rw=1, DO is driven combinationally with the addressed value; otherwise DO = 8'h00.
REQ-019 Peripheral read value per bit: the ORx bit when the DDRx bit is 1, otherwise the PxI bit.
REQ-020 PxO = ORx & DDRx; bits configured as inputs drive 0.
REQ-021 CRx[1] selects the active Cx1 edge (0 = falling, 1 = rising); CRx[0] enables the Cx1 interrupt.
REQ-022 Edges are detected by comparing each input with its value registered on the previous clock edge.
REQ-023 CRx[7] is set on an active Cx1 edge, independent of CRx[0].
REQ-024 CRx[5]=0 puts Cx2 in input mode: CRx[4] selects the active Cx2I edge (0 = falling, 1 = rising); CRx[3] enables the interrupt; CRx[6] is set on an active edge.
REQ-025 CRx[5]=1 puts Cx2 in output mode, and CRx[6] is held at 0 in this mode.
REQ-026 Output mode, CRx[4]=1: CxO2 = CRx[3].
REQ-027 Output mode, CRx[4:3]=00 (handshake): Cx2O goes 0 after the port access (A: read of ORA; B: write of ORB) and returns to 1 on the next active Cx1 edge.
REQ-028 Output mode, CRx[4:3]=01 (pulse): Cx2O is 0 for exactly one clock after the port access (A: read of ORA; B: write of ORB).
REQ-029 Any read of ORx (RS selects ORx with CRx[2]=1, rw=1, selected) clears CRx[7] and CRx[6] at that clock edge.
REQ-030 If a flag set and a flag clear occur in the same cycle, the set wins.
REQ-031 irqx = ~((CRx[7] & CRx[0]) | (CRx[6] & CRx[3] & ~CRx[5])), combinational.

Reset
REQ-032 Reset SHALL clear DDRx, ORx and CRx to 0.
REQ-033 During reset: PAO = PBO = 0; DO = 0; CA2O = CB2O = 1; irqA = irqB = 1.
REQ-034 Reset SHALL set all edge-history registers to 1.
REQ-035 Reset mid-access SHALL abort the access with no register update.

Structure
REQ-036 A shared package SHALL hold the RS address constants (ORA/DDRA = 0, CRA = 1, ORB/DDRB = 2, CRB = 3) and the CR bit-index constants.
REQ-037 One sub-module, pia_port, SHALL implement a single side (DDR, OR, CR, edge detect, C2 logic, irq); it is instantiated twice, with a parameter selecting read-strobe (A) or write-strobe (B) handshake.
REQ-038 Total RTL SHALL be roughly 150-300 lines.

Verification
REQ-039 Reset, then read RS=01 -> DO=00h, irqA=1, irqB=1.
REQ-040 Write CRA=01h; drive CA1 1->0; read CRA -> DO=81h and irqA=0; CA1 0->1 -> no further change.
REQ-041 Write CRA=05h; read RS=00 with DDRA=00h and PAI=FFh -> DO=FFh; next read of CRA -> DO=05h, irqA=1.
REQ-042 DDRA=0Fh, ORA=A5h, PAI=F0h -> PAO=05h; ORA read -> DO=F5h.
REQ-043 CRA=2Ch (pulse mode): read ORA -> CA2O=0 for exactly one cycle. CRB=24h (handshake): write ORB -> CB2O=0 until a CB1 falling edge.
REQ-044 CRB=09h: CB2I 1->0 -> CRB[6]=1, irqB=0. Repeat with CS=3'b111 -> reads return DO=00h and writes have no effect.
